// File: rtl/keypad_entry_ctrl.sv
// Keypad entry sequencer: assembles BCD digits from scanner strobes, presents the entry via RDY/ACK.
// Latency: one cycle from key strobe to VALUE/LEN/RDY and pulses. A key arriving in HOLD is dropped (DROP pulse).
module keypad_entry_ctrl #(
  parameter int DIGITS  = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic                         CLK,
  input  logic                         RSTN,
  input  logic                         V,
  input  logic [3:0]                   N,
  input  logic                         ACK,
  output logic [4*DIGITS-1:0]          VALUE,
  output logic [$clog2(DIGITS+1)-1:0]  LEN,
  output logic                         RDY,
  output logic                         OVF,
  output logic                         TMO,
  output logic                         DROP
);

  localparam int LW = $clog2(DIGITS + 1);
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [LW-1:0] FULL  = LW'(DIGITS);
  localparam logic [TW-1:0] TO_V  = TW'(TIMEOUT);
  localparam logic [TW-1:0] T_MAX = '1;

  typedef enum logic [1:0] {IDLE, ENTRY, HOLD} state_t;

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] value_d;
  logic [LW-1:0]       len_d;
  logic [TW-1:0]       tmr_q, tmr_d, tmr_inc;
  logic                ovf_d, tmo_d, drop_d;
  logic                is_dig, is_clr, is_ent;

  assign is_dig  = V && (N <= 4'd9);
  assign is_clr  = V && (N == 4'd10);
  assign is_ent  = V && (N == 4'd11);
  assign tmr_inc = (tmr_q == T_MAX) ? tmr_q : tmr_q + TW'(1);

  always_comb begin
    state_d = state_q;
    value_d = VALUE;
    len_d   = LEN;
    tmr_d   = tmr_q;
    ovf_d   = 1'b0;
    tmo_d   = 1'b0;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_dig) begin
          value_d      = '0;
          value_d[3:0] = N;
          len_d        = LW'(1);
          tmr_d        = '0;
          state_d      = ENTRY;
        end
      end
      ENTRY: begin
        if (is_dig) begin
          tmr_d = '0;
          if (LEN == FULL) begin
            ovf_d = 1'b1;
          end else begin
            value_d      = VALUE << 4;
            value_d[3:0] = N;
            len_d        = LEN + LW'(1);
          end
        end else if (is_clr) begin
          value_d = '0;
          len_d   = '0;
          tmr_d   = '0;
          state_d = IDLE;
        end else if (is_ent) begin
          tmr_d   = '0;
          state_d = HOLD;
        end else if (TIMEOUT != 0 && tmr_inc == TO_V) begin
          // invalid codes count as idle, so they cannot rescue an expiring entry
          value_d = '0;
          len_d   = '0;
          tmr_d   = '0;
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      HOLD: begin
        drop_d = V;
        if (ACK) begin
          value_d = '0;
          len_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        value_d = '0;
        len_d   = '0;
        tmr_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= IDLE;
      VALUE   <= '0;
      LEN     <= '0;
      tmr_q   <= '0;
      RDY     <= 1'b0;
      OVF     <= 1'b0;
      TMO     <= 1'b0;
      DROP    <= 1'b0;
    end else begin
      state_q <= state_d;
      VALUE   <= value_d;
      LEN     <= len_d;
      tmr_q   <= tmr_d;
      RDY     <= (state_d == HOLD);
      OVF     <= ovf_d;
      TMO     <= tmo_d;
      DROP    <= drop_d;
    end
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed scenarios then random keys, each cycle compared to a digit-queue model.
module tb_keypad_entry_ctrl;

  localparam int DIG = 4;
  localparam int TO  = 20;

  logic        clk = 1'b0;
  logic        rstn, v, ack;
  logic [3:0]  n;
  logic [15:0] value;
  logic [2:0]  len;
  logic        rdy, ovf, tmo, drop;

  int errors = 0;
  int checks = 0;

  // model: digits held, whether the entry is being presented, cycles since last valid key
  int q[$];
  bit holding;
  int quiet;
  bit e_ovf, e_tmo, e_drop;

  keypad_entry_ctrl #(.DIGITS(DIG), .TIMEOUT(TO)) dut (
    .CLK(clk), .RSTN(rstn), .V(v), .N(n), .ACK(ack),
    .VALUE(value), .LEN(len), .RDY(rdy), .OVF(ovf), .TMO(tmo), .DROP(drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_value();
    int acc = 0;
    foreach (q[i]) acc = acc * 16 + q[i];
    return acc;
  endfunction

  task automatic model_edge(input bit mv, input int mn, input bit mack, input bit mrst_n);
    e_ovf = 0; e_tmo = 0; e_drop = 0;
    if (!mrst_n) begin
      q.delete(); holding = 0; quiet = 0;
    end else if (holding) begin
      if (mv) e_drop = 1;
      if (mack) begin holding = 0; q.delete(); end
    end else if (q.size() == 0) begin
      if (mv && mn <= 9) begin q.push_back(mn); quiet = 0; end
    end else begin
      if (mv && mn <= 9) begin
        if (q.size() < DIG) q.push_back(mn); else e_ovf = 1;
        quiet = 0;
      end else if (mv && mn == 10) begin
        q.delete();
      end else if (mv && mn == 11) begin
        holding = 1;
      end else begin
        quiet++;
        if (quiet == TO) begin q.delete(); e_tmo = 1; end
      end
    end
  endtask

  task automatic step(input bit sv, input int sn, input bit sack, input bit srst_n);
    @(negedge clk);
    v = sv; n = 4'(sn); ack = sack; rstn = srst_n;
    @(posedge clk);
    model_edge(sv, sn, sack, srst_n);
    #1;
    chk("value", 32'(value), 32'(model_value()));
    chk("len",   32'(len),   32'(q.size()));
    chk("rdy",   32'(rdy),   32'(holding));
    chk("ovf",   32'(ovf),   32'(e_ovf));
    chk("tmo",   32'(tmo),   32'(e_tmo));
    chk("drop",  32'(drop),  32'(e_drop));
  endtask

  task automatic key(input int k);
    step(1, k, 0, 1);
  endtask

  task automatic idle(input int cyc);
    for (int i = 0; i < cyc; i++) step(0, 0, 0, 1);
  endtask

  initial begin
    int rate;
    int r;
    v = 0; n = 0; ack = 0; rstn = 0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("reset_value", 32'(value), 0);
    chk("reset_rdy", 32'(rdy), 0);

    // 1,2,3,# with gaps, then acknowledge
    key(1); idle(5); key(2); idle(5); key(3); idle(5); key(11);
    chk("plan_value", 32'(value), 32'h0123);
    chk("plan_len", 32'(len), 3);
    chk("plan_rdy", 32'(rdy), 1);
    step(0, 0, 1, 1);
    chk("ack_rdy", 32'(rdy), 0);
    idle(2);

    // overflow on fifth digit, then clear
    key(9); key(8); key(7); key(6); key(5);
    chk("ovf_pulse", 32'(ovf), 1);
    chk("ovf_value", 32'(value), 32'h9876);
    idle(1);
    chk("ovf_one_cycle", 32'(ovf), 0);
    key(10);
    chk("clr_len", 32'(len), 0);

    // timeout exactly TO cycles after the key, then rescued at cycle TO-1
    key(4); idle(TO - 1);
    chk("tmo_early", 32'(tmo), 0);
    idle(1);
    chk("tmo_pulse", 32'(tmo), 1);
    key(4); idle(TO - 2); key(4);
    chk("rescue_value", 32'(value), 32'h0044);
    idle(3);
    key(10);

    // HOLD with 7: drop without ack, then drop with ack
    key(7); key(11);
    key(5);
    chk("hold_drop", 32'(drop), 1);
    chk("hold_value", 32'(value), 32'h0007);
    step(1, 5, 1, 1);
    chk("ack_drop", 32'(drop), 1);
    chk("ack_len", 32'(len), 0);
    idle(1);

    // edge cases: # and * in IDLE, ACK outside HOLD, invalid code, reset mid-entry
    key(11); key(10);
    chk("idle_hash_rdy", 32'(rdy), 0);
    step(0, 0, 1, 1);
    key(2); step(0, 0, 1, 1);
    key(13);
    chk("code13_len", 32'(len), 1);
    key(3);
    step(0, 0, 0, 0);
    chk("rst_mid_len", 32'(len), 0);
    chk("rst_mid_tmo", 32'(tmo), 0);
    idle(2);

    // random traffic with varying key density
    rate = 4;
    for (int c = 0; c < 4000; c++) begin
      if (c % 60 == 0) begin
        r = $urandom_range(0, 2);
        rate = (r == 0) ? 2 : (r == 1) ? 5 : 40;
      end
      step($urandom_range(0, rate - 1) == 0,
           ($urandom_range(0, 3) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9),
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 299) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
